md6_msg_loader: RTL and testbench
=================================

Name: md6_msg_loader

Overview:
- Upstream feeder for the single-compression-function MD6 top level.
- Accepts the message as a stream of 64-bit words over a valid/ready handshake and assembles them into the 4096-bit message block.
- Computes the padding-zero count and drives the compression function's enable.
- Holds the block stable until the compression function reports done, then clears itself for the next message.

Parameters:
- WORD_W, 64: stream word width in bits; equals MD6 w.
- BLOCK_WORDS, 64: words per compression-function message block; block width is WORD_W*BLOCK_WORDS = 4096.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- s_data  input  64  message word; first message bit is s_data[63].
- s_valid  input  1  s_data, s_last and s_last_bits are valid.
- s_last  input  1  marks the final word of the message.
- s_last_bits  input  7  number of valid bits in the final word, 1..64; 0 is read as 64; ignored unless s_last=1.
- s_ready  output  1  loader accepts a word this cycle.
- M  output  4096  assembled block; word i sits at M[4095-64*i -: 64].
- padding_zero_M  output  16  equals 4096 minus the number of message bits.
- cf_enable  output  1  enable to the compression function.
- cf_done  input  1  done from the compression function.
- busy  output  1  high from acceptance of the first word until return to FILL.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FILL.
  - M=0, padding_zero_M=0, cf_enable=0, busy=0, word counter=0.
  - s_ready=1 once reset is released.
- A transfer occurs on a rising clk edge when s_valid & s_ready.
- State FILL:
  - s_ready=1, cf_enable=0.
  - On each transfer, s_data is written to word slot cnt and cnt increments (7-bit).
  - busy is set on the first transfer.
- Final word: a transfer with s_last=1, or the transfer that fills slot 63 even without s_last.
  - Bits below the valid bits are zeroed: with n valid bits, s_data[63-n:0] is forced to 0.
  - If the 64th word arrives without s_last, all 64 bits are valid.
  - padding_zero_M is registered as 4096 - (64*cnt_before + n), within the same edge.
  - Next state is HASH.
- State HASH:
  - s_ready=0, cf_enable=1 from the cycle after the final transfer; latency is 1 cycle.
  - M and padding_zero_M are held constant.
  - cf_done is ignored in the first HASH cycle (stale-done guard). From the second HASH cycle on, cf_done=1 moves the state to CLEAR.
- State CLEAR, one cycle:
  - cf_enable=0, s_ready=0.
  - M, padding_zero_M and cnt are cleared to 0; busy=0.
  - Next state is FILL.
  - s_ready is therefore high 2 cycles after cf_done is sampled.
- Unwritten word slots are always 0, because the block is cleared before each message.
- s_valid while s_ready=0 is not a transfer. The source must hold its data; there is no loss and no error.
- Empty messages (0 bits) are unsupported; the minimum message is 1 bit.
- Mid-operation reset (reset=0 in any state): all outputs go immediately to their reset values, and cf_enable drops asynchronously.
- s_last_bits is 7 bits wide; the value 64 is encoded as 0 or as 7'd64, and both mean 64.
- padding_zero_M range: 0 (full block) to 4095 (1-bit message).

Decomposition:
- Shared include/parameters file holds:
  - WORD_W and BLOCK_WORDS, tied to the existing `w and block constants.
  - Block width 4096.
  - The state encoding constants FILL, HASH and CLEAR.
- One natural sub-module, md6_last_word_mask: a combinational mask generator mapping s_last_bits to a 64-bit mask (MSB-aligned ones).

Test Plan:
- 3 words, s_last_bits=64 on word 3 (A..A, B..B, C..C):
  - M[4095:3904] = A,B,C; rest 0; padding_zero_M=3904.
  - cf_enable rises 1 cycle after word 3; s_ready=0.
- 1 word 0xFFFF_FFFF_FFFF_FFFF with s_last, s_last_bits=8:
  - M[4095:4088]=8'hFF, M[4087:0]=0, padding_zero_M=4088.
- 64 words, s_last never asserted:
  - Loader enters HASH after word 64; padding_zero_M=0.
  - Word 0 at M[4095:4032], word 63 at M[63:0].
- cf_done held high when HASH is entered, then dropped, then pulsed at HASH cycle 5:
  - No exit on HASH cycle 1; exit on the pulse.
  - s_ready=1 two cycles later; M=0.
- s_valid held high continuously during HASH with a word 0x1234:
  - No transfer occurs and M is unchanged.
  - After CLEAR, 0x1234 is accepted as word 0 of the next message.
- reset=0 asserted mid-FILL (after 10 words) and mid-HASH:
  - cf_enable=0 and M=0 asynchronously.
  - After release, s_ready=1 and a new 2-word message loads correctly.

Source files
------------

// File: rtl/md6_msg_loader_pkg.sv
// MD6 message loader shared constants and types.
// Block geometry, loader state encoding and padding arithmetic.
package md6_msg_loader_pkg;

  localparam int MD6_W           = 64;
  localparam int MD6_BLOCK_WORDS = 64;
  localparam int MD6_BLOCK_W     = MD6_W * MD6_BLOCK_WORDS;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HASH  = 2'd1,
    CLEAR = 2'd2
  } ld_state_t;

  // Zero bits left in the block after the given full words plus tail bits.
  function automatic logic [15:0] pad_count(
    input logic [15:0] words,
    input logic [15:0] bits
  );
    return 16'(MD6_BLOCK_W) - (words * 16'(MD6_W) + bits);
  endfunction

endpackage

// File: rtl/md6_last_word_mask.sv
// Tail-word mask for the MD6 loader.
// Maps a valid-bit count to MSB-aligned ones; 0 or >WORD_W means full.
module md6_last_word_mask #(
  parameter int WORD_W = 64,
  parameter int NB_W   = $clog2(WORD_W) + 1
) (
  input  logic [NB_W-1:0]   last_bits,
  output logic [NB_W-1:0]   n_bits,
  output logic [WORD_W-1:0] mask
);

  // Normalise the count, then keep the top n_bits bits.
  always_comb begin
    n_bits = last_bits;
    if (last_bits == '0 || last_bits > NB_W'(WORD_W))
      n_bits = NB_W'(WORD_W);
    mask = ~({WORD_W{1'b1}} >> n_bits);
  end

endmodule

// File: rtl/md6_msg_loader.sv
// MD6 message loader: streams 64-bit words into one 4096-bit block.
// Drives the compression enable and clears after done.
module md6_msg_loader
  import md6_msg_loader_pkg::*;
#(
  parameter int WORD_W      = MD6_W,
  parameter int BLOCK_WORDS = MD6_BLOCK_WORDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  input  logic [$clog2(WORD_W):0]       s_last_bits,
  output logic                          s_ready,
  output logic [WORD_W*BLOCK_WORDS-1:0] M,
  output logic [15:0]                   padding_zero_M,
  output logic                          cf_enable,
  input  logic                          cf_done,
  output logic                          busy
);

  localparam int NB_W   = $clog2(WORD_W) + 1;
  localparam int SLOT_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = SLOT_W + 1;

  ld_state_t state, state_nxt;

  logic [BLOCK_WORDS-1:0][WORD_W-1:0] blk;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       pad;
  logic              busy_q;
  logic              armed;

  logic              xfer;
  logic              final_word;
  logic [NB_W-1:0]   lb_sel;
  logic [NB_W-1:0]   n_bits;
  logic [WORD_W-1:0] mask;
  logic [SLOT_W-1:0] slot;
  logic [15:0]       pad_nxt;

  assign xfer       = s_valid & s_ready;
  assign final_word = s_last | (cnt == CNT_W'(BLOCK_WORDS - 1));
  assign lb_sel     = s_last ? s_last_bits : '0;
  assign slot       = SLOT_W'(BLOCK_WORDS - 1) - cnt[SLOT_W-1:0];
  assign pad_nxt    = pad_count(16'(cnt), 16'(n_bits));

  md6_last_word_mask #(
    .WORD_W (WORD_W),
    .NB_W   (NB_W)
  ) u_mask (
    .last_bits (lb_sel),
    .n_bits    (n_bits),
    .mask      (mask)
  );

  assign M              = blk;
  assign padding_zero_M = pad;
  assign busy           = busy_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // Next state and handshake/enable outputs.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cf_enable = 1'b0;
    unique case (state)
      FILL: begin
        s_ready = reset;
        if (s_valid && reset && final_word)
          state_nxt = HASH;
      end
      HASH: begin
        cf_enable = 1'b1;
        if (armed && cf_done)
          state_nxt = CLEAR;
      end
      CLEAR: state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Block assembly, word count, padding and busy tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk    <= '0;
      cnt    <= '0;
      pad    <= '0;
      busy_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= (state == HASH);
      unique case (state)
        FILL: begin
          if (xfer) begin
            blk[slot] <= s_data & mask;
            cnt       <= cnt + 1'b1;
            busy_q    <= 1'b1;
            if (final_word)
              pad <= pad_nxt;
          end
        end
        CLEAR: begin
          blk    <= '0;
          cnt    <= '0;
          pad    <= '0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md6_msg_loader.sv
// Directed self-checking bench for md6_msg_loader.
// Hand-computed blocks, padding counts and handshake timing.
module tb_md6_msg_loader;

  logic          clk;
  logic          reset;
  logic [63:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic [6:0]    s_last_bits;
  logic          s_ready;
  logic [4095:0] M;
  logic [15:0]   padding_zero_M;
  logic          cf_enable;
  logic          cf_done;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4095:0] exp_m;

  md6_msg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_last_bits    (s_last_bits),
    .s_ready        (s_ready),
    .M              (M),
    .padding_zero_M (padding_zero_M),
    .cf_enable      (cf_enable),
    .cf_done        (cf_done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_m(input string tag, input logic [4095:0] exp);
    int bad;
    n_assert++;
    assert (M === exp) else begin
      n_fail++;
      bad = 0;
      for (int i = 63; i >= 0; i--)
        if (M[4095-64*i -: 64] !== exp[4095-64*i -: 64]) bad = i;
      $error("FAIL %s: word %0d observed %h expected %h", tag, bad,
             M[4095-64*bad -: 64], exp[4095-64*bad -: 64]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l,
                      input logic [6:0] b);
    s_data      = d;
    s_valid     = 1'b1;
    s_last      = l;
    s_last_bits = b;
    tick(1);
    s_valid     = 1'b0;
    s_last      = 1'b0;
  endtask

  task automatic finish_hash(input string tag);
    tick(1);
    cf_done = 1'b1;
    tick(1);
    cf_done = 1'b0;
    check({tag, "_clr_en"}, cf_enable, 1'b0);
    check({tag, "_clr_rdy"}, s_ready, 1'b0);
    tick(1);
    check({tag, "_fill_rdy"}, s_ready, 1'b1);
    check({tag, "_fill_busy"}, busy, 1'b0);
    check({tag, "_fill_pad"}, padding_zero_M, 16'd0);
    check_m({tag, "_fill_m"}, '0);
  endtask

  initial begin
    reset       = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_last_bits = '0;
    cf_done     = 1'b0;

    // Reset state
    #2;
    check("rst_en", cf_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pad", padding_zero_M, 16'd0);
    check_m("rst_m", '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_rdy", s_ready, 1'b1);
    tick(1);

    // Three full words
    send({16{4'hA}}, 1'b0, 7'd0);
    check("t1_busy", busy, 1'b1);
    check("t1_rdy", s_ready, 1'b1);
    send({16{4'hB}}, 1'b0, 7'd0);
    check("t1_en_fill", cf_enable, 1'b0);
    send({16{4'hC}}, 1'b1, 7'd64);
    exp_m = '0;
    exp_m[4095:3904] = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}};
    check("t1_en", cf_enable, 1'b1);
    check("t1_rdy_hash", s_ready, 1'b0);
    check("t1_pad", padding_zero_M, 16'd3904);
    check_m("t1_m", exp_m);
    finish_hash("t1");

    // One word, 8 valid bits
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd8);
    exp_m = '0;
    exp_m[4095:4032] = 64'hFF00_0000_0000_0000;
    check("t2_pad", padding_zero_M, 16'd4088);
    check_m("t2_m", exp_m);
    finish_hash("t2");

    // One word, 1 valid bit
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd1);
    exp_m = '0;
    exp_m[4095:4032] = 64'h8000_0000_0000_0000;
    check("t2b_pad", padding_zero_M, 16'd4095);
    check_m("t2b_m", exp_m);
    finish_hash("t2b");

    // One word, last_bits 0 read as 64
    send(64'h0123_4567_89AB_CDEF, 1'b1, 7'd0);
    exp_m = '0;
    exp_m[4095:4032] = 64'h0123_4567_89AB_CDEF;
    check("t2c_pad", padding_zero_M, 16'd4032);
    check_m("t2c_m", exp_m);
    finish_hash("t2c");

    // 64 words with no s_last
    exp_m = '0;
    for (int i = 0; i < 64; i++) begin
      send({8'hA5, 48'h0, 8'(i)}, 1'b0, 7'd0);
      exp_m[4095-64*i -: 64] = {8'hA5, 48'h0, 8'(i)};
      if (i == 62) begin
        check("t3_rdy63", s_ready, 1'b1);
        check("t3_en63", cf_enable, 1'b0);
      end
    end
    check("t3_en", cf_enable, 1'b1);
    check("t3_pad", padding_zero_M, 16'd0);
    check("t3_w0", M[4095:4032], 64'hA500_0000_0000_0000);
    check("t3_w63", M[63:0], 64'hA500_0000_0000_003F);
    check_m("t3_m", exp_m);
    finish_hash("t3");

    // Stale done guard
    cf_done = 1'b1;
    send(64'h5555_5555_5555_5555, 1'b1, 7'd64);
    check("t4_en_c1", cf_enable, 1'b1);
    tick(1);
    check("t4_stale", cf_enable, 1'b1);
    cf_done = 1'b0;
    tick(3);
    check("t4_en_c5", cf_enable, 1'b1);
    cf_done = 1'b1;
    tick(1);
    cf_done = 1'b0;
    check("t4_clr_en", cf_enable, 1'b0);
    check("t4_clr_rdy", s_ready, 1'b0);
    tick(1);
    check("t4_rdy", s_ready, 1'b1);
    check_m("t4_m", '0);

    // s_valid held through HASH
    send(64'hDEAD_BEEF_0000_0001, 1'b1, 7'd64);
    s_valid     = 1'b1;
    s_data      = 64'h1234;
    s_last      = 1'b1;
    s_last_bits = 7'd64;
    tick(2);
    exp_m = '0;
    exp_m[4095:4032] = 64'hDEAD_BEEF_0000_0001;
    check("t5_rdy", s_ready, 1'b0);
    check("t5_pad", padding_zero_M, 16'd4032);
    check_m("t5_hold", exp_m);
    cf_done = 1'b1;
    tick(1);
    cf_done = 1'b0;
    check_m("t5_clr_hold", exp_m);
    tick(1);
    check("t5_fill_rdy", s_ready, 1'b1);
    check_m("t5_fill_m", '0);
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_m = '0;
    exp_m[4095:4032] = 64'h1234;
    check("t5_en", cf_enable, 1'b1);
    check("t5_pad2", padding_zero_M, 16'd4032);
    check_m("t5_m", exp_m);
    finish_hash("t5");

    // Reset mid-FILL
    for (int i = 0; i < 10; i++)
      send(64'h1111_0000_0000_0000 + 64'(i), 1'b0, 7'd0);
    check("t6_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_en", cf_enable, 1'b0);
    check("t6_busy_rst", busy, 1'b0);
    check_m("t6_m", '0);
    tick(1);
    reset = 1'b1;
    #1;
    check("t6_rdy", s_ready, 1'b1);
    tick(1);

    // Reset mid-HASH
    send(64'h2222_2222_2222_2222, 1'b0, 7'd0);
    send(64'h3333_3333_3333_3333, 1'b1, 7'd64);
    check("t7_en_hash", cf_enable, 1'b1);
    reset = 1'b0;
    #1;
    check("t7_en", cf_enable, 1'b0);
    check("t7_pad", padding_zero_M, 16'd0);
    check_m("t7_m", '0);
    tick(1);
    reset = 1'b1;
    #1;
    check("t7_rdy", s_ready, 1'b1);
    tick(1);

    // Two-word message after reset, 32-bit tail
    send(64'h0123_4567_89AB_CDEF, 1'b0, 7'd0);
    send(64'hFEDC_BA98_7654_3210, 1'b1, 7'd32);
    exp_m = '0;
    exp_m[4095:3968] = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_0000_0000};
    check("t8_en", cf_enable, 1'b1);
    check("t8_pad", padding_zero_M, 16'd4000);
    check_m("t8_m", exp_m);
    finish_hash("t8");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
